// File: rtl/exec_wb_stage.sv
// exec_wb_stage: execute/write-back stage with E->W pipeline, operand forwarding,
// condition codes, retired-instruction counter and sticky halt on illegal instructions.
module exec_wb_stage #(
    parameter int         NREG    = 6,
    parameter logic [3:0] NONE_ID = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] valA,
    input  logic [31:0] valB,
    output logic        wb_en,
    output logic [3:0]  dstE,
    output logic [31:0] valE,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic        halted,
    output logic [15:0] retired
);
    typedef enum logic [2:0] {OP_IRMOV, OP_ADD, OP_SUB, OP_AND, OP_XOR} op_t;
    typedef enum logic {RUN, HALT} state_t;

    localparam logic [3:0] NREG4 = NREG[3:0];

    state_t      state;
    logic        eValid;
    op_t         eOp;
    logic [3:0]  eDst;
    logic [31:0] eA, eB;
    logic [15:0] eC;

    wire [3:0]  icode = instr[31:28];
    wire [3:0]  ifun  = instr[27:24];
    wire [3:0]  rA    = instr[23:20];
    wire [3:0]  rB    = instr[19:16];
    wire [15:0] valC  = instr[15:0];

    op_t         op;
    logic        legal;
    logic [31:0] eRes, srcA, srcB;
    logic        eOf;

    always_comb begin
        op    = OP_IRMOV;
        legal = 1'b0;
        case ({icode, ifun})
            8'h10: begin op = OP_IRMOV; legal = rB < NREG4; end
            8'h20: begin op = OP_ADD;   legal = rA < NREG4 && rB < NREG4; end
            8'h21: begin op = OP_SUB;   legal = rA < NREG4 && rB < NREG4; end
            8'h32: begin op = OP_AND;   legal = rA < NREG4 && rB < NREG4; end
            8'h33: begin op = OP_XOR;   legal = rA < NREG4 && rB < NREG4; end
            default: begin op = OP_IRMOV; legal = 1'b0; end
        endcase
    end

    wire isNop   = instr == 32'h0;
    wire illegal = in_valid && !isNop && !legal;
    wire issue   = in_valid && !isNop && legal;

    // E's in-flight result takes priority over the older one sitting in W
    assign srcA = (eValid && rA == eDst) ? eRes : (wb_en && rA == dstE) ? valE : valA;
    assign srcB = (eValid && rB == eDst) ? eRes : (wb_en && rB == dstE) ? valE : valB;

    always_comb begin
        eRes = {16'b0, eC};
        eOf  = 1'b0;
        case (eOp)
            OP_ADD: begin
                eRes = eB + eA;
                eOf  = (eA[31] == eB[31]) && (eRes[31] != eB[31]);
            end
            OP_SUB: begin
                eRes = eB - eA;
                eOf  = (eA[31] != eB[31]) && (eRes[31] != eB[31]);
            end
            OP_AND:  eRes = eB & eA;
            OP_XOR:  eRes = eB ^ eA;
            default: eRes = {16'b0, eC};
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            eValid  <= 1'b0;
            eOp     <= OP_IRMOV;
            eDst    <= NONE_ID;
            eA      <= '0;
            eB      <= '0;
            eC      <= '0;
            wb_en   <= 1'b0;
            dstE    <= NONE_ID;
            valE    <= '0;
            zf      <= 1'b0;
            sf      <= 1'b0;
            of      <= 1'b0;
            retired <= '0;
        end else begin
            wb_en <= eValid;
            dstE  <= eValid ? eDst : NONE_ID;
            valE  <= eValid ? eRes : '0;
            if (eValid)
                retired <= retired + 16'd1;
            if (eValid && eOp != OP_IRMOV) begin
                zf <= eRes == '0;
                sf <= eRes[31];
                of <= eOf;
            end
            if (state == HALT) begin
                eValid <= 1'b0;
            end else if (illegal) begin
                state  <= HALT;
                eValid <= 1'b0;
            end else begin
                eValid <= issue;
                eOp    <= op;
                eDst   <= rB;
                eA     <= srcA;
                eB     <= srcB;
                eC     <= valC;
            end
        end
    end

    assign halted = state == HALT;
endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: directed vectors; expected register writes go to a scoreboard
// queue drained by an independent write-port monitor, other state checked inline.
module tb_exec_wb_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0, valA = '0, valB = '0;
    logic        wb_en, zf, sf, of, halted;
    logic [3:0]  dstE;
    logic [31:0] valE;
    logic [15:0] retired;

    typedef struct packed {
        logic [3:0]  d;
        logic [31:0] v;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    exec_wb_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .instr(instr),
        .valA(valA), .valB(valB), .wb_en(wb_en), .dstE(dstE), .valE(valE),
        .zf(zf), .sf(sf), .of(of), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // present one slot, then return just after the capturing edge
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        instr    = i;
        valA     = a;
        valB     = b;
        @(posedge clock);
        #1;
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic expect_wr(input logic [3:0] d, input logic [31:0] v);
        wr_t w;
        w.d = d;
        w.v = v;
        expQ.push_back(w);
    endtask

    always @(negedge clock) begin
        if (reset && wb_en) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got dstE=%h valE=%h expected no write", dstE, valE);
            end else begin
                wr_t w;
                w = expQ.pop_front();
                chk("wb_dstE", {28'b0, dstE}, {28'b0, w.d});
                chk("wb_valE", valE, w.v);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
        chk("rst_dstE", {28'b0, dstE}, 32'hF);
        chk("rst_valE", valE, 32'h0);
        chk("rst_cc", {29'b0, zf, sf, of}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_retired", {16'b0, retired}, 32'd0);
        reset = 1'b1;

        // IRMOV r1,0x1234
        step(1'b1, 32'h10F11234, 32'h0, 32'h0); expect_wr(4'd1, 32'h1234);
        bubble(1);
        chk("irmov_retired", {16'b0, retired}, 32'd1);
        chk("irmov_cc", {29'b0, zf, sf, of}, 32'd0);
        bubble(1);

        // dependent chain, ports stale: both ADD operands must be forwarded
        step(1'b1, 32'h10F10003, 32'h0, 32'h0); expect_wr(4'd1, 32'h3);
        step(1'b1, 32'h10F20002, 32'h0, 32'h0); expect_wr(4'd2, 32'h2);
        step(1'b1, 32'h20120000, 32'h0, 32'h0); expect_wr(4'd2, 32'h5);
        bubble(1);
        chk("add_cc", {29'b0, zf, sf, of}, 32'd0);
        chk("add_retired", {16'b0, retired}, 32'd4);

        // r3 via W forward, r0 via port; signed overflow then XOR to zero
        step(1'b1, 32'h10F30001, 32'h0, 32'h0); expect_wr(4'd3, 32'h1);
        bubble(1);
        step(1'b1, 32'h20300000, 32'h0, 32'h7FFFFFFF); expect_wr(4'd0, 32'h80000000);
        step(1'b1, 32'h33000000, 32'h7FFFFFFF, 32'h7FFFFFFF); expect_wr(4'd0, 32'h0);
        chk("ovf_cc_zso", {29'b0, zf, sf, of}, 32'b011);
        bubble(1);
        chk("xor_cc_zso", {29'b0, zf, sf, of}, 32'b100);
        chk("xor_retired", {16'b0, retired}, 32'd7);

        // SUB to zero, then NOP must not write, count or touch CCs
        step(1'b1, 32'h21120000, 32'h5, 32'h5); expect_wr(4'd2, 32'h0);
        step(1'b1, 32'h00000000, 32'h0, 32'h0);
        chk("sub_cc_zso", {29'b0, zf, sf, of}, 32'b100);
        chk("sub_retired", {16'b0, retired}, 32'd8);
        bubble(1);
        chk("nop_wb_en", {31'b0, wb_en}, 32'd0);
        chk("nop_cc_zso", {29'b0, zf, sf, of}, 32'b100);
        chk("nop_retired", {16'b0, retired}, 32'd8);

        // illegal opcode: preceding IRMOV completes, later ADD discarded
        step(1'b1, 32'h10F10001, 32'h0, 32'h0); expect_wr(4'd1, 32'h1);
        step(1'b1, 32'h40000000, 32'h0, 32'h0);
        chk("halt_rise", {31'b0, halted}, 32'd1);
        step(1'b1, 32'h20120000, 32'h1, 32'h1);
        bubble(3);
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        chk("halt_retired", {16'b0, retired}, 32'd9);
        chk("halt_cc_zso", {29'b0, zf, sf, of}, 32'b100);

        reset = 1'b0;
        #1;
        chk("rst2_halted", {31'b0, halted}, 32'd0);
        chk("rst2_retired", {16'b0, retired}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // register ID boundary: r5 legal, r6 illegal
        step(1'b1, 32'h10F5FFFF, 32'h0, 32'h0); expect_wr(4'd5, 32'h0000FFFF);
        step(1'b1, 32'h10F60000, 32'h0, 32'h0);
        chk("reg6_halt", {31'b0, halted}, 32'd1);
        bubble(2);
        chk("reg6_retired", {16'b0, retired}, 32'd1);

        reset = 1'b0;
        #1;
        @(posedge clock); #1;
        reset = 1'b1;

        // reset with two instructions in flight: nothing may be written
        step(1'b1, 32'h10F10011, 32'h0, 32'h0);
        step(1'b1, 32'h10F20022, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        chk("midrst_wb_en", {31'b0, wb_en}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        bubble(4);
        chk("midrst_retired", {16'b0, retired}, 32'd0);
        chk("scoreboard_drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
